branch_resolver: RTL
====================

// Module: branch_resolver
// PURPOSE
//  Execute-stage end of the branch-prediction loop. Queues each fetch-time prediction in order,
//  checks it against the actual outcome when the branch resolves, raises flush/redirect on a
//  mispredict, and drives the predictor's update write port (branch/branchPC/branchAddr).
//  Sits between the fetch unit (prediction push) and the execute stage (resolution).
// PARAMETERS
//  DEPTH         4    in-flight prediction queue entries (power of 2, >=2)
//  FLUSH_CYCLES  2    cycles flush stays high after a mispredict (>=1)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst           in   1   asynchronous, active-high reset
//  pred_valid    in   1   fetch pushes a prediction for a branch this cycle
//  pred_pc       in   16  PC of the predicted branch
//  pred_addr     in   16  predicted target; 16'hFFFF = predicted not-taken
//  q_full        out  1   queue full; fetch must stall pushes
//  ex_valid      in   1   branch resolves in execute this cycle (program order)
//  ex_pc         in   16  PC of resolving branch
//  ex_taken      in   1   actual direction
//  ex_target     in   16  actual taken target
//  flush         out  1   squash younger instructions
//  redirect_pc   out  16  correct fetch PC, valid while flush=1
//  upd_valid     out  1   predictor write enable (drives predictor 'branch')
//  upd_pc        out  16  predictor write PC (drives 'branchPC')
//  upd_addr      out  16  predictor write target (drives 'branchAddr')
//  order_err     out  1   sticky: resolution PC did not match queue head
//  resolve_cnt   out  16  resolved branches, saturating
//  mispred_cnt   out  16  mispredicts, saturating
// BEHAVIOUR
//  Reset: all outputs 0, queue empty, FSM=RUN, counters 0. Async assert, sync release.
//  Queue: FIFO, wrapping rd/wr pointers + count. q_full = (count==DEPTH), combinational from count.
//  - Push when pred_valid && FSM==RUN; push while full is dropped (count unchanged).
//  - Pop when ex_valid && FSM==RUN && count>0. Push+pop same cycle: count unchanged, both act.
//  Resolution (RUN, ex_valid): head = {hpc,haddr} if count>0 else {ex_pc,16'hFFFF}.
//  - pred_taken = (haddr != 16'hFFFF).
//  - mispredict = (pred_taken != ex_taken) | (ex_taken & haddr != ex_target) | (count>0 & hpc != ex_pc).
//  - hpc != ex_pc with count>0 sets order_err (sticky until reset).
//  - upd_valid/upd_pc/upd_addr registered, 1-cycle pulse next cycle, when ex_taken && haddr != ex_target;
//    upd_addr = ex_target, upd_pc = ex_pc. No update for not-taken outcomes.
//  - resolve_cnt +1 per resolution; mispred_cnt +1 per mispredict; both hold at 16'hFFFF.
//  FSM: RUN -> FLUSH on mispredict. In FLUSH: flush=1, redirect_pc held, down-counter from
//  FLUSH_CYCLES-1; FLUSH -> RUN when counter==0. Queue cleared on the RUN->FLUSH edge.
//  - flush and redirect_pc registered: first high the cycle after the mispredicting ex_valid.
//  - redirect_pc = ex_taken ? ex_target : ex_pc + 1 (16-bit wrap, 16'hFFFF+1 = 0).
//  - In FLUSH, pred_valid and ex_valid are ignored (no push, pop, update or count).
//  - The upd pulse of the mispredicting branch is still issued (first FLUSH cycle).
//  Pointers wrap mod DEPTH; count never exceeds DEPTH or goes below 0.
//  rst mid-flush: returns to RUN, queue empty, flush=0 immediately.
// TESTING
//  Push {pc=10,addr=FFFF}; resolve pc=10 not-taken -> no flush, no upd, resolve_cnt=1.
//  Push {pc=20,addr=FFFF}; resolve pc=20 taken tgt=40 -> next cycle flush=1 for 2 cycles, redirect=40,
//   upd_valid pulse pc=20 addr=40, mispred_cnt=1, q_full=0 after flush.
//  Push {pc=30,addr=50}; resolve pc=30 not-taken -> flush, redirect_pc=31, no upd.
//  Push 5 predictions with no resolves (DEPTH=4) -> q_full=1 after 4th, 5th dropped; 4 resolves match.
//  Push+resolve same cycle with count=2 -> count stays 2; resolve pc=FFFF not-taken mispredict -> redirect=0.
//  Resolve pc=7 with head pc=8 -> order_err=1, flush; assert rst during flush -> all outputs 0 at once.

Source files
------------

// File: rtl/branch_resolver.sv
// branch_resolver
//   Execute-stage end of the branch-prediction loop. Fetch-time predictions are
//   queued in program order. Each resolving branch is compared against the
//   prediction at the head of the queue. On a mispredict the block raises flush
//   and redirect_pc and clears the queue. Taken branches whose predicted target
//   was wrong are written back to the predictor.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   pred_valid/pc/addr        prediction push from fetch (addr 16'hFFFF = not-taken)
//   q_full                    queue full, fetch must stall pushes
//   ex_valid/pc/taken/target  branch resolution from execute, in program order
//   flush, redirect_pc        squash younger instructions and refetch from redirect_pc
//   upd_valid/pc/addr         predictor write port, one-cycle pulse
//   order_err                 sticky: resolving PC did not match the queue head
//   resolve_cnt, mispred_cnt  saturating event counters
//
// state | meaning
// RUN   | accepting pushes and resolutions
// FLUSH | flush asserted, redirect held, all inputs ignored

module branch_resolver #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid,
    input  logic [15:0] pred_pc,
    input  logic [15:0] pred_addr,
    output logic        q_full,
    input  logic        ex_valid,
    input  logic [15:0] ex_pc,
    input  logic        ex_taken,
    input  logic [15:0] ex_target,
    output logic        flush,
    output logic [15:0] redirect_pc,
    output logic        upd_valid,
    output logic [15:0] upd_pc,
    output logic [15:0] upd_addr,
    output logic        order_err,
    output logic [15:0] resolve_cnt,
    output logic [15:0] mispred_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [15:0] NOT_TAKEN = 16'hFFFF;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t state, state_nxt;

    logic [15:0]   q_pc   [DEPTH];
    logic [15:0]   q_addr [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [FW-1:0] fcnt;

    logic        running, resolve, head_valid, pred_taken;
    logic        do_push, do_pop, mispredict, upd_now;
    logic [15:0] hpc, haddr;

    assign running    = (state == RUN);
    assign resolve    = running && ex_valid;
    assign head_valid = (count != '0);
    assign q_full     = (count == FULL_CNT);
    assign flush      = (state == FLUSH);

    // With an empty queue the branch is treated as predicted not-taken at its own PC.
    assign hpc        = head_valid ? q_pc[rd_ptr]   : ex_pc;
    assign haddr      = head_valid ? q_addr[rd_ptr] : NOT_TAKEN;
    assign pred_taken = (haddr != NOT_TAKEN);

    assign mispredict = resolve && ((pred_taken != ex_taken)
                                    || (ex_taken && (haddr != ex_target))
                                    || (head_valid && (hpc != ex_pc)));
    assign upd_now    = resolve && ex_taken && (haddr != ex_target);

    // A push into a full queue is dropped even if a pop happens in the same cycle.
    assign do_push = running && pred_valid && !q_full;
    assign do_pop  = resolve && head_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mispredict)   state_nxt = FLUSH;
            FLUSH:   if (fcnt == '0)   state_nxt = RUN;
            default:                   state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            q_pc[wr_ptr]   <= pred_pc;
            q_addr[wr_ptr] <= pred_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fcnt        <= '0;
            redirect_pc <= '0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_addr    <= '0;
            order_err   <= 1'b0;
            resolve_cnt <= '0;
            mispred_cnt <= '0;
        end else begin
            if (mispredict) begin
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                fcnt        <= FW'(FLUSH_CYCLES - 1);
                redirect_pc <= ex_taken ? ex_target : ex_pc + 16'd1;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({do_push, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (flush && fcnt != '0) fcnt <= fcnt - FW'(1);
            end

            upd_valid <= upd_now;
            upd_pc    <= upd_now ? ex_pc : 16'd0;
            upd_addr  <= upd_now ? ex_target : 16'd0;

            if (resolve && head_valid && (hpc != ex_pc)) order_err <= 1'b1;
            if (resolve && resolve_cnt != 16'hFFFF)      resolve_cnt <= resolve_cnt + 16'd1;
            if (mispredict && mispred_cnt != 16'hFFFF)   mispred_cnt <= mispred_cnt + 16'd1;
        end
    end

endmodule
